// File: rtl/iter_shifter_if.sv
// iter_shifter handshake bundle: request (in_valid/in_ready, A, B, H)
// and response (out_valid/out_ready, Result) plus the busy status.
interface iter_shifter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       H;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             busy;

  modport master (
    output in_valid, A, B, H, out_ready,
    input  in_ready, out_valid, Result, busy
  );

  modport slave (
    input  in_valid, A, B, H, out_ready,
    output in_ready, out_valid, Result, busy
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: shifts at most STEP bits per cycle.
// Ports: clk, rst (async high), bus (iter_shifter_if.slave).
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input logic           clk,
  input logic           rst,
  iter_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  // rem never exceeds WIDTH-1, so a STEP of WIDTH or more
  // behaves as "take the whole remainder in one cycle".
  localparam int STEP_C = (STEP >= WIDTH) ? WIDTH - 1 : STEP;
  localparam logic [SHW-1:0] STEP_K = SHW'(STEP_C);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   work, work_nx, result;
  logic [2*WIDTH-1:0] tmp;
  logic [SHW-1:0]     rem, rem_nx, k, amt;
  logic [2:0]         mode;
  logic               sign;
  logic               direct;

  wire unused_b = ^bus.B[WIDTH-1:SHW];

  assign amt    = bus.B[SHW-1:0];
  assign direct = (amt == '0) || (bus.H[2:1] == 2'b11);
  assign k      = (rem > STEP_K) ? STEP_K : rem;
  assign rem_nx = rem - k;

  always_comb begin
    tmp     = '0;
    work_nx = work;
    case (mode)
      3'b000: work_nx = work << k;
      3'b001: work_nx = work >> k;
      3'b010, 3'b011: begin
        // fill comes from the sign captured at accept
        tmp     = {{WIDTH{sign}}, work} >> k;
        work_nx = tmp[WIDTH-1:0];
      end
      3'b100: begin
        tmp     = {work, work} << k;
        work_nx = tmp[2*WIDTH-1:WIDTH];
      end
      3'b101: begin
        tmp     = {work, work} >> k;
        work_nx = tmp[WIDTH-1:0];
      end
      default: work_nx = work;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.in_valid)
          state_nx = direct ? DONE : SHIFT;
      SHIFT:
        if (rem_nx == '0)
          state_nx = DONE;
      DONE:
        if (bus.out_ready)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work   <= '0;
      rem    <= '0;
      mode   <= '0;
      sign   <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.in_valid) begin
            work <= bus.A;
            rem  <= amt;
            mode <= bus.H;
            sign <= bus.A[WIDTH-1];
            if (direct) result <= bus.A;
          end
        SHIFT: begin
          work <= work_nx;
          rem  <= rem_nx;
          if (rem_nx == '0) result <= work_nx;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.Result    = result;
endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (WIDTH=32, STEP=8).
// Reference model computes shifts with plain arithmetic.
module tb_iter_shifter;
  localparam int W  = 32;
  localparam int ST = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_shifter_if #(.WIDTH(W)) bus ();

  iter_shifter #(.WIDTH(W), .STEP(ST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] model_res = '0;
  logic [W-1:0] prev_res  = '0;

  task automatic check(string name,
                       logic [W-1:0] act,
                       logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(
      logic [W-1:0] a, logic [W-1:0] b, logic [2:0] h);
    int s;
    s = int'(b % W);
    case (h)
      3'd0: return a << s;
      3'd1: return a >> s;
      3'd2, 3'd3: return $signed(a) >>> s;
      3'd4: return (s == 0) ? a : (a << s) | (a >> (W - s));
      3'd5: return (s == 0) ? a : (a >> s) | (a << (W - s));
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(logic [W-1:0] b,
                                 logic [2:0] h);
    int s;
    s = int'(b % W);
    if (s == 0 || h[2:1] == 2'b11) return 1;
    return (s + ST - 1) / ST + 1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_vs_busy", W'(bus.in_ready), W'(!bus.busy));
      if (bus.out_valid)
        check("result", bus.Result, model_res);
      else
        check("hold", bus.Result, prev_res);
    end
    prev_res = bus.Result;
  end

  task automatic launch(logic [W-1:0] a, logic [W-1:0] b,
                        logic [2:0] h);
    int g;
    model_res    = ref_shift(a, b, h);
    bus.A        = a;
    bus.B        = b;
    bus.H        = h;
    bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [2:0] h,
                       input int stall,
                       output logic [W-1:0] res);
    int lat, bn;
    bus.out_ready = 1'b0;
    launch(a, b, h);
    lat = 1;
    bn  = bus.busy ? 1 : 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) bn++;
    end
    res = bus.Result;
    check("latency", W'(lat), W'(ref_lat(b, h)));
    repeat (stall) begin
      @(posedge clk); #1;
      if (bus.busy) bn++;
    end
    check("busy_cycles", W'(bn), W'(ref_lat(b, h) + stall));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("ready_after", W'(bus.in_ready), 1);
    check("valid_after", W'(bus.out_valid), 0);
  endtask

  initial begin
    logic [W-1:0] r;
    int g;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.H = '0;

    #12;
    check("rst_in_ready", W'(bus.in_ready), 1);
    check("rst_out_valid", W'(bus.out_valid), 0);
    check("rst_busy", W'(bus.busy), 0);
    check("rst_result", bus.Result, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    check("pin_sll", ref_shift(32'h1, 32'd5, 3'b000), 32'h20);
    check("pin_sra", ref_shift(32'h80000000, 32'd31, 3'b010),
          32'hFFFFFFFF);
    check("pin_srl", ref_shift(32'h80000000, 32'd31, 3'b001), 32'h1);
    check("pin_ror", ref_shift(32'h12345678, 32'd8, 3'b101),
          32'h78123456);
    check("pin_rol", ref_shift(32'h80000001, 32'h21, 3'b100), 32'h3);
    check("pin_lat_sra", W'(ref_lat(32'd31, 3'b010)), 5);

    do_op(32'h1, 32'd5, 3'b000, 0, r);
    check("sll", r, 32'h20);
    do_op(32'h80000000, 32'd31, 3'b010, 0, r);
    check("sra", r, 32'hFFFFFFFF);
    do_op(32'h80000000, 32'd31, 3'b001, 0, r);
    check("srl", r, 32'h1);
    do_op(32'h12345678, 32'd8, 3'b101, 0, r);
    check("ror", r, 32'h78123456);
    do_op(32'h80000001, 32'h21, 3'b100, 0, r);
    check("rol_masked", r, 32'h3);
    do_op(32'hDEADBEEF, 32'd0, 3'b001, 0, r);
    check("zero_amt", r, 32'hDEADBEEF);
    do_op(32'hCAFEF00D, 32'd12, 3'b110, 0, r);
    check("pass", r, 32'hCAFEF00D);

    // back-pressure with a competing request during the stall
    bus.out_ready = 1'b0;
    launch(32'h0F0F0F0F, 32'd4, 3'b001);
    g = 0;
    while (!bus.out_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("bp_reach_done", W'(bus.out_valid), 1);
    bus.A        = 32'hFFFFFFFF;
    bus.B        = 32'd1;
    bus.H        = 3'b000;
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid", W'(bus.out_valid), 1);
      check("bp_in_ready", W'(bus.in_ready), 0);
      check("bp_result", bus.Result, 32'h00F0F0F0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_ready", W'(bus.in_ready), 1);
    @(posedge clk); #1;
    check("bp_not_taken", W'(bus.busy), 0);

    // asynchronous reset in the middle of a shift
    launch(32'h80000000, 32'd31, 3'b010);
    @(posedge clk); #1;
    check("mid_busy_pre", W'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_out_valid", W'(bus.out_valid), 0);
    check("mid_busy", W'(bus.busy), 0);
    check("mid_result", bus.Result, 0);
    check("mid_in_ready", W'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(32'h3, 32'd2, 3'b000, 0, r);
    check("after_rst", r, 32'hC);

    for (int i = 0; i < 3000; i++) begin
      do_op($urandom, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
